noc_route_ctrl: RTL and testbench
=================================

Name: noc_route_ctrl

Overview:
- Input-port controller sitting directly downstream of the router input FIFO.
- Pops flits from the FIFO and decodes the head flit's destination.
- Computes the output port with dimension-ordered XY routing, requests that port from the switch allocator, holds the grant for the whole packet, and streams flits out until the tail flit.
- One instance per router input port.

Parameters:
- DATA_WIDTH, 8, flit width; [DATA_WIDTH-1:DATA_WIDTH-2] = flit type, then dest X, then dest Y, rest payload.
- COORD_W, 2, width of each destination coordinate field.
- LOCAL_X, 0, this router's X coordinate.
- LOCAL_Y, 0, this router's Y coordinate.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- en  in  1  global enable; 0 freezes all state (no pop, no request change).
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_WIDTH  FIFO read data; valid the cycle after fifo_read.
- fifo_read  out  1  FIFO pop strobe.
- out_req  out  5  one-hot output-port request {L,W,E,S,N} = bits [4:0] as {4,3,2,1,0}.
- out_gnt  in  5  one-hot grant from the switch allocator.
- out_ready  in  1  crossbar/downstream able to accept a flit this cycle.
- flit_out  out  DATA_WIDTH  forwarded flit.
- flit_valid  out  1  flit_out valid, single-cycle pulse per flit.
- out_sel  out  5  one-hot crossbar select; equals the granted port while a packet is held.

Behaviour:
- Flit type encoding: 2'b01 HEAD, 2'b00 BODY, 2'b10 TAIL, 2'b11 HEAD_TAIL (single-flit packet).
- Reset (rst=0, asynchronous): state=IDLE.
  - fifo_read, out_req, flit_valid, out_sel = 0.
  - flit_out = 0; latched route = 0.
- en=0: all registers hold; fifo_read=0; out_req holds its current value.
- States and transitions:
  - IDLE: if !fifo_empty, assert fifo_read for 1 cycle -> HEAD_WAIT.
  - HEAD_WAIT: fifo_data holds the head. Latch the flit and compute the route -> REQ.
  - REQ: drive out_req = route. When out_gnt & route != 0, latch out_sel = route and drop out_req -> SEND.
  - SEND: drive flit_out = latched flit, flit_valid=1 when out_ready=1.
    - If out_ready=0, hold and retry next cycle.
    - After sending, a TAIL or HEAD_TAIL flit goes -> IDLE and clears out_sel.
    - Otherwise -> BODY_RD.
  - BODY_RD: if !fifo_empty && out_ready, assert fifo_read -> BODY_WAIT; else wait here.
  - BODY_WAIT: latch fifo_data -> SEND.
- XY route, unsigned compare of COORD_W-bit fields:
  - dx>LOCAL_X -> E; dx<LOCAL_X -> W.
  - Otherwise dy>LOCAL_Y -> N; dy<LOCAL_Y -> S.
  - Otherwise L.
- Throughput: one flit per 3 cycles steady state (BODY_RD, BODY_WAIT, SEND).
- Head latency: 3 cycles from fifo_empty=0 to out_req, with no wait states.
- fifo_read is never asserted while fifo_empty=1; at most one outstanding pop.
- A grant on a port other than the route is ignored.
- out_req stays asserted until a matching grant arrives; no timeout.
- out_sel stays constant from grant through the tail flit's SEND cycle.
- Reset mid-packet: immediate return to IDLE and release of out_sel. Flits of the partial packet remaining in the FIFO are then processed as-is. In the default build, which has no checking, the next flit is treated as a head.

Optional Feature:
- Macro NOC_FLIT_CHECK_EN.
- When defined:
  - Adds output port flit_err (1 bit, reset 0).
  - A BODY or TAIL flit popped in HEAD_WAIT is dropped (no request), flit_err pulses 1 cycle, and the FSM returns to IDLE.
  - A HEAD or HEAD_TAIL flit popped in BODY_WAIT is forwarded as a TAIL (type field rewritten to 2'b10), flit_err pulses, and the FSM ends the packet.
- When undefined: no flit_err port; the type field is trusted.

Decomposition:
- Package noc_pkg holds:
  - flit type constants FLIT_HEAD/BODY/TAIL/HEAD_TAIL;
  - port one-hot constants PORT_N/S/E/W/L;
  - FSM state encodings;
  - field-offset localparams derived from DATA_WIDTH and COORD_W.
- Sub-module noc_xy_route: purely combinational; takes dest X/Y plus LOCAL_X/LOCAL_Y and returns the one-hot port. Shared with the other input ports.

Test Plan:
- LOCAL=(1,1); single HEAD_TAIL 8'b11_10_01_00 (dx=2, dy=1), immediate grant -> out_req=5'b00100 (E) at cycle 3. Flit forwarded once and returns to IDLE.
- 3-flit packet to (1,3): HEAD, BODY, TAIL; out_ready=1; grant immediate -> N requested; three flit_valid pulses 3 cycles apart; out_sel=5'b00001 throughout, cleared after the TAIL.
- Packet to (1,1) with grant delayed 5 cycles; out_gnt=5'b00010 pulsed first -> L held on out_req, wrong-port grant ignored, no flit sent before grant.
- FIFO runs empty mid-packet (BODY missing 4 cycles) plus out_ready=0 for 2 cycles on SEND -> no fifo_read while empty; flit_out stable until accepted; no flit lost or duplicated.
- rst driven low mid-body for 1 cycle -> out_sel=0, out_req=0 asynchronously; next non-empty FIFO triggers a fresh head fetch.
- With NOC_FLIT_CHECK_EN: BODY as first flit -> flit_err pulse, no out_req; HEAD arriving mid-packet -> forwarded with type 2'b10 and flit_err pulse.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit types, port one-hots, FSM states, field offsets.
// Used by noc_route_ctrl and noc_xy_route.
package noc_pkg;

  localparam logic [1:0] FLIT_BODY      = 2'b00;
  localparam logic [1:0] FLIT_HEAD      = 2'b01;
  localparam logic [1:0] FLIT_TAIL      = 2'b10;
  localparam logic [1:0] FLIT_HEAD_TAIL = 2'b11;

  localparam logic [4:0] PORT_N = 5'b00001;
  localparam logic [4:0] PORT_S = 5'b00010;
  localparam logic [4:0] PORT_E = 5'b00100;
  localparam logic [4:0] PORT_W = 5'b01000;
  localparam logic [4:0] PORT_L = 5'b10000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEAD_WAIT,
    ST_REQ,
    ST_SEND,
    ST_BODY_RD,
    ST_BODY_WAIT
  } state_t;

  // Flit layout, MSB first: type(2), dest X, dest Y, payload.
  function automatic int type_lsb(input int dw);
    return dw - 2;
  endfunction

  function automatic int x_lsb(input int dw, input int cw);
    return dw - 2 - cw;
  endfunction

  function automatic int y_lsb(input int dw, input int cw);
    return dw - 2 - 2 * cw;
  endfunction

  function automatic logic is_head(input logic [1:0] t);
    return (t == FLIT_HEAD) || (t == FLIT_HEAD_TAIL);
  endfunction

  function automatic logic is_tail(input logic [1:0] t);
    return (t == FLIT_TAIL) || (t == FLIT_HEAD_TAIL);
  endfunction

endpackage

// File: rtl/noc_xy_route.sv
// Dimension-ordered XY route: resolve X first, then Y, else local.
// Purely combinational; shared by all router input ports.
module noc_xy_route
  import noc_pkg::*;
#(
  parameter int COORD_W = 2
) (
  input  logic [COORD_W-1:0] dx,
  input  logic [COORD_W-1:0] dy,
  input  logic [COORD_W-1:0] lx,
  input  logic [COORD_W-1:0] ly,
  output logic [4:0]         port
);

  always_comb begin
    port = PORT_L;
    priority case (1'b1)
      (dx > lx): port = PORT_E;
      (dx < lx): port = PORT_W;
      (dy > ly): port = PORT_N;
      (dy < ly): port = PORT_S;
      default:   port = PORT_L;
    endcase
  end

endmodule

// File: rtl/noc_route_ctrl.sv
// Input-port controller: pops flits, XY-routes the head, holds the grant per packet.
// Define NOC_FLIT_CHECK_EN to add flit type checking and the flit_err output.
module noc_route_ctrl
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int COORD_W    = 2,
  parameter int LOCAL_X    = 0,
  parameter int LOCAL_Y    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read,
  output logic [4:0]            out_req,
  input  logic [4:0]            out_gnt,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] flit_out,
  output logic                  flit_valid,
  output logic [4:0]            out_sel
`ifdef NOC_FLIT_CHECK_EN
  ,
  output logic                  flit_err
`endif
);

  localparam int TL = type_lsb(DATA_WIDTH);
  localparam int XL = x_lsb(DATA_WIDTH, COORD_W);
  localparam int YL = y_lsb(DATA_WIDTH, COORD_W);
  localparam logic [COORD_W-1:0] LX = COORD_W'(LOCAL_X);
  localparam logic [COORD_W-1:0] LY = COORD_W'(LOCAL_Y);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] flit_q, flit_d;
  logic [4:0]            route_q, route_d;
  logic [4:0]            sel_q, sel_d;
  logic [4:0]            route_w;
  logic                  head_bad;
  logic                  body_bad;

  noc_xy_route #(
    .COORD_W(COORD_W)
  ) u_route (
    .dx  (fifo_data[XL +: COORD_W]),
    .dy  (fifo_data[YL +: COORD_W]),
    .lx  (LX),
    .ly  (LY),
    .port(route_w)
  );

`ifdef NOC_FLIT_CHECK_EN
  logic [1:0] in_type;
  assign in_type  = fifo_data[TL +: 2];
  assign head_bad = !is_head(in_type);
  assign body_bad = is_head(in_type);
  assign flit_err = en && rst &&
    (((state_q == ST_HEAD_WAIT) && head_bad) ||
     ((state_q == ST_BODY_WAIT) && body_bad));
`else
  assign head_bad = 1'b0;
  assign body_bad = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    flit_d     = flit_q;
    route_d    = route_q;
    sel_d      = sel_q;
    fifo_read  = 1'b0;
    flit_valid = 1'b0;
    if (en && rst) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            fifo_read = 1'b1;
            state_d   = ST_HEAD_WAIT;
          end
        end
        ST_HEAD_WAIT: begin
          if (head_bad) begin
            state_d = ST_IDLE;
          end else begin
            flit_d  = fifo_data;
            route_d = route_w;
            state_d = ST_REQ;
          end
        end
        ST_REQ: begin
          if ((out_gnt & route_q) != 5'd0) begin
            sel_d   = route_q;
            state_d = ST_SEND;
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            flit_valid = 1'b1;
            if (is_tail(flit_q[TL +: 2])) begin
              sel_d   = '0;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_BODY_RD;
            end
          end
        end
        ST_BODY_RD: begin
          if (!fifo_empty && out_ready) begin
            fifo_read = 1'b1;
            state_d   = ST_BODY_WAIT;
          end
        end
        ST_BODY_WAIT: begin
          flit_d = fifo_data;
          // A stray head mid-packet closes the packet.
          if (body_bad) flit_d[TL +: 2] = FLIT_TAIL;
          state_d = ST_SEND;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      flit_q  <= '0;
      route_q <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      flit_q  <= flit_d;
      route_q <= route_d;
      sel_q   <= sel_d;
    end
  end

  assign out_req  = (state_q == ST_REQ) ? route_q : 5'd0;
  assign flit_out = flit_q;
  assign out_sel  = sel_q;

endmodule

// File: tb/tb_noc_route_ctrl.sv
// Bench for noc_route_ctrl at LOCAL=(1,1): FIFO and allocator models, flit scoreboard.
// Flit-check cases are included when NOC_FLIT_CHECK_EN is defined.
module tb_noc_route_ctrl;
  import noc_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, fifo_empty, fifo_read;
  logic       flit_valid, out_ready;
  logic [7:0] fifo_data, flit_out;
  logic [4:0] out_req, out_gnt, out_sel;
`ifdef NOC_FLIT_CHECK_EN
  logic       flit_err;
  int         nerr;
`endif

  always #5 clk = ~clk;

  noc_route_ctrl #(
    .DATA_WIDTH(8),
    .COORD_W   (2),
    .LOCAL_X   (1),
    .LOCAL_Y   (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_read (fifo_read),
    .out_req   (out_req),
    .out_gnt   (out_gnt),
    .out_ready (out_ready),
    .flit_out  (flit_out),
    .flit_valid(flit_valid),
    .out_sel   (out_sel)
`ifdef NOC_FLIT_CHECK_EN
    ,
    .flit_err  (flit_err)
`endif
  );

  typedef struct {
    logic [7:0] f;
    logic [4:0] s;
  } exp_t;

  typedef struct {
    logic [7:0] flit;
    logic [4:0] route;
  } vec_t;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [7:0] fq[$];
  exp_t       sb[$];
  int         fv_cyc[$];
  bit         rd_pend;
  int         nreads;
  int         gnt_delay, wrong_at, req_cnt, req_cycles;
  logic [4:0] wrong_val, first_req_val;
  int         first_req_cyc, push_cyc, snap, n;
  vec_t       tbl[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic bound(input string nm, input int cnt, input int lim);
    total++;
    if (cnt >= lim) begin
      bad++;
      $display("FAIL %s: timeout after %0d cycles", nm, cnt);
    end
  endtask

  function automatic int fvc(input int i);
    return (i < fv_cyc.size()) ? fv_cyc[i] : -1000;
  endfunction

  // One clock: monitor + allocator at negedge, FIFO model after posedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    rd_pend = fifo_read;
    if (fifo_read) begin
      nreads++;
      chk("rd_nonempty", {31'd0, fifo_empty}, 32'd0);
    end
`ifdef NOC_FLIT_CHECK_EN
    if (flit_err) nerr++;
`endif
    if (flit_valid) begin
      fv_cyc.push_back(cyc);
      chk("valid_ready", {31'd0, out_ready}, 32'd1);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexp_flit: got %0h want none", flit_out);
      end else begin
        e = sb.pop_front();
        chk("flit", {24'd0, flit_out}, {24'd0, e.f});
        chk("sel", {27'd0, out_sel}, {27'd0, e.s});
      end
    end
    if (out_req != 5'd0) begin
      req_cnt++;
      req_cycles++;
      if (first_req_cyc < 0) begin
        first_req_cyc = cyc;
        first_req_val = out_req;
      end
      if (req_cnt > gnt_delay) out_gnt = out_req;
      else if (req_cnt == wrong_at) out_gnt = wrong_val;
      else out_gnt = 5'd0;
    end else begin
      req_cnt = 0;
      out_gnt = 5'd0;
    end
    @(posedge clk);
    #1;
    if (rd_pend) fifo_data = (fq.size() > 0) ? fq.pop_front() : 8'hEE;
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic push(input logic [7:0] f, input logic [4:0] s);
    exp_t e;
    e.f = f;
    e.s = s;
    fq.push_back(f);
    sb.push_back(e);
    fifo_empty = 1'b0;
  endtask

  task automatic start_pkt();
    push_cyc = cyc + 1;
    first_req_cyc = -1;
    req_cycles = 0;
    fv_cyc.delete();
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while ((sb.size() != 0 || fq.size() != 0 || out_sel != 5'd0) && k < 200) begin
      tick();
      k++;
    end
    bound(nm, k, 200);
    tick();
    tick();
  endtask

  initial begin
    tbl[0] = '{8'hCC, PORT_W};
    tbl[1] = '{8'hDC, PORT_N};
    tbl[2] = '{8'hD0, PORT_S};
    tbl[3] = '{8'hD7, PORT_L};
    tbl[4] = '{8'hF1, PORT_E};
    tbl[5] = '{8'hC2, PORT_W};

    rst = 1'b0; en = 1'b1; out_ready = 1'b1; out_gnt = 5'd0;
    fifo_data = 8'd0; fifo_empty = 1'b1; nreads = 0;
    gnt_delay = 0; wrong_at = -1; wrong_val = 5'd0; req_cnt = 0;
`ifdef NOC_FLIT_CHECK_EN
    nerr = 0;
`endif

    // Reset with a flit already waiting: nothing may move.
    start_pkt();
    push(8'hE4, PORT_E);
    tick();
    tick();
    chk("rst_rd", {31'd0, fifo_read}, 32'd0);
    chk("rst_req", {27'd0, out_req}, 32'd0);
    chk("rst_valid", {31'd0, flit_valid}, 32'd0);
    chk("rst_sel", {27'd0, out_sel}, 32'd0);
    chk("rst_flit", {24'd0, flit_out}, 32'd0);
    chk("rst_reads", nreads, 0);

    // HEAD_TAIL to (2,1): E in the 3rd cycle, one flit.
    rst = 1'b1;
    start_pkt();
    drain("t0_drain");
    chk("t0_lat", first_req_cyc - push_cyc + 1, 3);
    chk("t0_route", {27'd0, first_req_val}, {27'd0, PORT_E});
    chk("t0_nflit", fv_cyc.size(), 1);
    chk("t0_selclr", {27'd0, out_sel}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      start_pkt();
      push(tbl[i].flit, tbl[i].route);
      drain("tbl_drain");
      chk("tbl_route", {27'd0, first_req_val}, {27'd0, tbl[i].route});
      chk("tbl_lat", first_req_cyc - push_cyc + 1, 3);
      chk("tbl_nflit", fv_cyc.size(), 1);
      chk("tbl_gnt2flit", fvc(0) - first_req_cyc, 1);
    end

    // Three-flit packet to (1,3): N, flits 3 cycles apart.
    start_pkt();
    push(8'h5C, PORT_N);
    push(8'h2A, PORT_N);
    push(8'h95, PORT_N);
    drain("p3_drain");
    chk("p3_route", {27'd0, first_req_val}, {27'd0, PORT_N});
    chk("p3_nflit", fv_cyc.size(), 3);
    chk("p3_gap1", fvc(1) - fvc(0), 3);
    chk("p3_gap2", fvc(2) - fvc(1), 3);
    chk("p3_selclr", {27'd0, out_sel}, 32'd0);

    // Local packet, grant after 5 cycles, stray grant on S first.
    gnt_delay = 5; wrong_at = 2; wrong_val = PORT_S;
    start_pkt();
    push(8'hD5, PORT_L);
    drain("dly_drain");
    chk("dly_route", {27'd0, first_req_val}, {27'd0, PORT_L});
    chk("dly_reqcyc", req_cycles, 6);
    chk("dly_flit_at", fvc(0) - first_req_cyc, 6);
    gnt_delay = 0; wrong_at = -1; wrong_val = 5'd0;

    // FIFO starves mid-packet, then downstream stalls on SEND.
    start_pkt();
    push(8'h64, PORT_E);
    n = 0;
    while (fv_cyc.size() < 1 && n < 50) begin tick(); n++; end
    bound("st_head", n, 50);
    snap = nreads;
    repeat (4) tick();
    chk("st_noread", nreads - snap, 0);
    push(8'h33, PORT_E);
    n = 0;
    rd_pend = 1'b0;
    while (!rd_pend && n < 10) begin tick(); n++; end
    bound("st_bodyrd", n, 10);
    out_ready = 1'b0;
    tick();
    tick();
    chk("st_hold1", {24'd0, flit_out}, 32'h33);
    tick();
    chk("st_hold2", {24'd0, flit_out}, 32'h33);
    chk("st_stallcnt", fv_cyc.size(), 1);
    out_ready = 1'b1;
    push(8'h80, PORT_E);
    drain("st_drain");
    chk("st_nflit", fv_cyc.size(), 3);

    // Reset while waiting for a body flit.
    start_pkt();
    push(8'h64, PORT_E);
    push(8'h33, PORT_E);
    n = 0;
    while (fv_cyc.size() < 2 && n < 50) begin tick(); n++; end
    bound("mr_body", n, 50);
    chk("mr_sel", {27'd0, out_sel}, {27'd0, PORT_E});
    #2 rst = 1'b0;
    #1 chk("mr_arst_sel", {27'd0, out_sel}, 32'd0);
    chk("mr_arst_req", {27'd0, out_req}, 32'd0);
    tick();
    rst = 1'b1;
    start_pkt();
    push(8'hD5, PORT_L);
    drain("mr_drain");
    chk("mr_route", {27'd0, first_req_val}, {27'd0, PORT_L});
    chk("mr_lat", first_req_cyc - push_cyc + 1, 3);
    chk("mr_nflit", fv_cyc.size(), 1);

    // Reset while requesting: request drops at once.
    gnt_delay = 100;
    start_pkt();
    fq.push_back(8'hDC);
    fifo_empty = 1'b0;
    n = 0;
    while (out_req == 5'd0 && n < 20) begin tick(); n++; end
    bound("rr_req", n, 20);
    chk("rr_req", {27'd0, out_req}, {27'd0, PORT_N});
    #2 rst = 1'b0;
    #1 chk("rr_arst_req", {27'd0, out_req}, 32'd0);
    tick();
    rst = 1'b1;
    gnt_delay = 0;
    repeat (3) tick();
    chk("rr_noflit", fv_cyc.size(), 0);
    chk("rr_sel", {27'd0, out_sel}, 32'd0);

    // en=0 blocks the pop; en=0 in REQ holds the request.
    en = 1'b0;
    start_pkt();
    push(8'hE4, PORT_E);
    snap = nreads;
    repeat (3) tick();
    chk("en_noread", nreads - snap, 0);
    en = 1'b1;
    drain("en_drain1");
    chk("en_nflit1", fv_cyc.size(), 1);
    gnt_delay = 3;
    start_pkt();
    push(8'hCC, PORT_W);
    n = 0;
    while (out_req == 5'd0 && n < 20) begin tick(); n++; end
    bound("en_req", n, 20);
    en = 1'b0;
    repeat (4) tick();
    chk("en_reqhold", {27'd0, out_req}, {27'd0, PORT_W});
    chk("en_noflit", fv_cyc.size(), 0);
    en = 1'b1;
    gnt_delay = 0;
    drain("en_drain2");
    chk("en_nflit2", fv_cyc.size(), 1);

`ifdef NOC_FLIT_CHECK_EN
    start_pkt();
    fq.push_back(8'h2A);
    fifo_empty = 1'b0;
    snap = nerr;
    repeat (5) tick();
    chk("ck_body_err", nerr - snap, 1);
    chk("ck_body_noreq", first_req_cyc, -1);
    chk("ck_body_noflit", fv_cyc.size(), 0);
    start_pkt();
    snap = nerr;
    push(8'h64, PORT_E);
    push(8'h9C, PORT_E);
    fq.pop_back();
    fq.push_back(8'h5C);
    drain("ck_head_drain");
    chk("ck_head_err", nerr - snap, 1);
    chk("ck_head_nflit", fv_cyc.size(), 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
